// File: rtl/mux4way_rr.sv
// Four-input round-robin merge of valid/ready streams into one registered output
// stream. Each output word carries the index of the source it came from.
module mux4way_rr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  input  logic [WIDTH-1:0] inD,
  input  logic             validA,
  input  logic             validB,
  input  logic             validC,
  input  logic             validD,
  output logic             readyA,
  output logic             readyB,
  output logic             readyC,
  output logic             readyD,
  output logic [WIDTH-1:0] out,
  output logic             outValid,
  input  logic             outReady,
  output logic [1:0]       outSelect
);

  logic [WIDTH-1:0] data_arr [4];
  logic [3:0]       valid_vec;
  logic [3:0]       ready_vec;

  logic [WIDTH-1:0] data_reg;
  logic [1:0]       sel_reg;
  logic             valid_reg;
  logic [1:0]       last_grant_reg;

  logic             can_load;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             load;

  assign data_arr[0] = inA;
  assign data_arr[1] = inB;
  assign data_arr[2] = inC;
  assign data_arr[3] = inD;
  assign valid_vec   = {validD, validC, validB, validA};

  assign can_load = !valid_reg || outReady;

  // Search starts one past the last winner; the k=4 candidate wraps back onto
  // the last winner itself so a lone valid channel is always granted.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_reg + 2'(k);
      if (!grant_found && valid_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
      assign ready_vec[gi] = !reset && can_load && grant_found && (grant_idx == 2'(gi));
    end
  endgenerate

  assign readyA = ready_vec[0];
  assign readyB = ready_vec[1];
  assign readyC = ready_vec[2];
  assign readyD = ready_vec[3];
  assign load   = |ready_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg       <= '0;
      sel_reg        <= 2'd0;
      valid_reg      <= 1'b0;
      last_grant_reg <= 2'd3;
    end else if (load) begin
      data_reg       <= data_arr[grant_idx];
      sel_reg        <= grant_idx;
      valid_reg      <= 1'b1;
      last_grant_reg <= grant_idx;
    end else if (valid_reg && outReady) begin
      valid_reg      <= 1'b0;
    end
  end

  assign out       = data_reg;
  assign outSelect = sel_reg;
  assign outValid  = valid_reg;

endmodule

// File: tb/tb_mux4way_rr.sv
// Directed bench for mux4way_rr: stimulus pushes expected {select,data} words,
// a negedge monitor pops and compares on every sink transfer.
module tb_mux4way_rr;

  logic        clk;
  logic        reset;
  logic [15:0] inA, inB, inC, inD;
  logic        validA, validB, validC, validD;
  logic        readyA, readyB, readyC, readyD;
  logic [15:0] out;
  logic        outValid;
  logic        outReady;
  logic [1:0]  outSelect;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];

  mux4way_rr #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .validA(validA), .validB(validB), .validC(validC), .validD(validD),
    .readyA(readyA), .readyB(readyB), .readyC(readyC), .readyD(readyD),
    .out(out), .outValid(outValid), .outReady(outReady), .outSelect(outSelect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Sink-side monitor: every completed sink transfer must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sink_word: got sel=%0d data=%h, expected no word", outSelect, out);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({outSelect, out} !== e) begin
          errors++;
          $display("FAIL sink_word: got sel=%0d data=%h, expected sel=%0d data=%h",
                   outSelect, out, e[17:16], e[15:0]);
        end else begin
          $display("word sel=%0d data=%h", outSelect, out);
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] v, input logic ordy);
    reset    = rst;
    validA   = v[0];
    validB   = v[1];
    validC   = v[2];
    validD   = v[3];
    outReady = ordy;
  endtask

  task automatic check_ready(input string name, input logic [3:0] e);
    logic [3:0] a;
    a = {readyD, readyC, readyB, readyA};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: ready(DCBA)=%b, expected %b", name, a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    drive(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    check_ready("drain_ready", 4'b0000);
    next_cycle();
  endtask

  initial begin
    inA = 16'd1; inB = 16'd2; inC = 16'd3; inD = 16'd4;
    drive(1'b1, 4'b1111, 1'b1);

    // Reset held two cycles with every source valid
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_ready("reset_ready", 4'b0000);
      if (i == 1) begin
        check_val("reset_outValid", 32'(outValid), 32'd0);
        check_val("reset_out", 32'(out), 32'd0);
        check_val("reset_outSelect", 32'(outSelect), 32'd0);
      end
      next_cycle();
    end

    // Round-robin with all four valid: A,B,C,D,A,B,C,D
    drive(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'(i % 4), 16'(i % 4 + 1)});
      @(negedge clk);
      check_ready("rr_ready", 4'(1 << (i % 4)));
      next_cycle();
    end
    drain();

    // Lone source C streams one word per cycle
    inC = 16'h00C3;
    drive(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd2, 16'h00C3});
      @(negedge clk);
      check_ready("single_ready", 4'b0100);
      if (i > 0) begin
        check_val("single_out", 32'(out), 32'h00C3);
        check_val("single_sel", 32'(outSelect), 32'd2);
      end
      next_cycle();
    end
    drain();

    // Skip/wrap from lastGrant=2 with only A and C valid: A, C, A
    inA = 16'h00A1; inC = 16'h00C1;
    drive(1'b0, 4'b0101, 1'b1);
    exp_q.push_back({2'd0, 16'h00A1});
    @(negedge clk); check_ready("wrap_ready0", 4'b0001); next_cycle();
    exp_q.push_back({2'd2, 16'h00C1});
    @(negedge clk); check_ready("wrap_ready1", 4'b0100); next_cycle();
    exp_q.push_back({2'd0, 16'h00A1});
    @(negedge clk); check_ready("wrap_ready2", 4'b0001); next_cycle();
    drain();

    // Backpressure: B held while sink stalls, then A loads on release
    inB = 16'h0BBB;
    drive(1'b0, 4'b0010, 1'b0);
    exp_q.push_back({2'd1, 16'h0BBB});
    @(negedge clk); check_ready("bp_loadB", 4'b0010); next_cycle();
    inA = 16'h0AAA;
    drive(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ready("bp_stall_ready", 4'b0000);
      check_val("bp_outValid", 32'(outValid), 32'd1);
      check_val("bp_out", 32'(out), 32'h0BBB);
      check_val("bp_sel", 32'(outSelect), 32'd1);
      next_cycle();
    end
    outReady = 1'b1;
    exp_q.push_back({2'd0, 16'h0AAA});
    @(negedge clk); check_ready("bp_release", 4'b0001); next_cycle();
    drain();

    // Reset mid-stream discards the held D word, then A wins first
    inD = 16'h0DDD;
    drive(1'b0, 4'b1000, 1'b0);
    @(negedge clk); check_ready("mid_loadD", 4'b1000); next_cycle();
    drive(1'b1, 4'b1111, 1'b1);
    @(negedge clk); check_ready("mid_reset_ready", 4'b0000); next_cycle();
    inA = 16'd1; inB = 16'd2; inC = 16'd3; inD = 16'd4;
    drive(1'b0, 4'b1111, 1'b1);
    exp_q.push_back({2'd0, 16'd1});
    @(negedge clk);
    check_val("mid_outValid", 32'(outValid), 32'd0);
    check_ready("mid_firstA", 4'b0001);
    next_cycle();
    exp_q.push_back({2'd1, 16'd2});
    @(negedge clk); check_ready("mid_thenB", 4'b0010); next_cycle();
    drain();
    drain();

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
